// File: rtl/bench_bist_wrapper.sv
// bench_bist_wrapper: BIST wrapper that drives a combinational CUT from an LFSR and compacts its responses into a MISR
// Ports:
//   clk_i        single clock, all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   start_i      one-cycle request to begin a run (ignored while running)
//   abort_i      returns the block to IDLE from any state, wins over start_i
//   seed_i       LFSR seed, sampled on an accepted start (zero is replaced by 1)
//   golden_i     expected signature, sampled on an accepted start
//   cut_in_o     stimulus to the CUT, the current LFSR contents
//   cut_out_i    CUT response, sampled in the same cycle cut_in_o is presented
//   busy_o       high while patterns are being applied
//   done_o       high once PAT_CNT patterns have been compacted
//   pass_o       signature matches golden, only while done_o is high
//   signature_o  current MISR contents
//   pat_idx_o    number of patterns applied in the current run
module bench_bist_wrapper #(
    parameter int               IN_W      = 16,
    parameter int               OUT_W     = 23,
    parameter int               PAT_CNT   = 256,
    parameter logic [IN_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter logic [OUT_W-1:0] MISR_TAPS = 23'h420000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [IN_W-1:0]  seed_i,
    input  logic [OUT_W-1:0] golden_i,
    output logic [IN_W-1:0]  cut_in_o,
    input  logic [OUT_W-1:0] cut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [OUT_W-1:0] signature_o,
    output logic [15:0]      pat_idx_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [OUT_W-1:0] misr_q, misr_d, golden_q, golden_d;
    logic [15:0]      pat_idx_q, pat_idx_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             go, step, last;
    // go: accepted start; step: a pattern is applied this cycle (abort freezes the datapath)
    assign go   = start_i && !abort_i && state_q != RUN;
    assign step = state_q == RUN && !abort_i;
    assign last = pat_idx_q == 16'(PAT_CNT - 1);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    always_comb begin
        state_d = abort_i ? IDLE : go ? RUN : (step && last) ? DONE : state_q;
    end
    // Outputs are registered from the next state so they line up with state_q
    always_comb begin
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
        pass_d = done_d && misr_d == golden_d;
    end
    // A zero seed is replaced by 1 so the LFSR never enters its lock-up state
    always_comb begin
        lfsr_d    = go ? (seed_i == '0 ? IN_W'(1) : seed_i)
                  : step ? (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0) : lfsr_q;
        misr_d    = go ? '0
                  : step ? ((misr_q >> 1) ^ (misr_q[0] ? MISR_TAPS : '0)) ^ cut_out_i : misr_q;
        pat_idx_d = go ? '0 : step ? pat_idx_q + 16'd1 : pat_idx_q;
        golden_d  = go ? golden_i : golden_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q    <= IN_W'(1);
            misr_q    <= '0;
            pat_idx_q <= '0;
            golden_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            pat_idx_q <= pat_idx_d;
            golden_q  <= golden_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end
    assign cut_in_o    = lfsr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign signature_o = misr_q;
    assign pat_idx_o   = pat_idx_q;
endmodule
